silhouette_stats: RTL and testbench
===================================

# silhouette_stats

Downstream consumer of the interlaced 1-bit silhouette frame buffer. On each `start` it scans one 320x240 frame in row-major order by driving the buffer's `read_addr` and `reading` inputs, and it accumulates from the returned `pixel_out` stream. Per frame it reports the foreground pixel count, the bounding box and the floor-rounded centroid. Results feed the pose-scoring logic.

## Interface
- `H_PIXELS`, 320, frame width
- `V_PIXELS`, 240, frame height
- `READ_LATENCY`, 2, cycles from `read_addr` presented to matching `pixel_in` valid at this block
- `clk`  in  1  system clock, all logic on posedge
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset`=0 clears all state)
- `start`  in  1  single-cycle request to scan one frame; ignored while `busy`
- `read_addr`  out  17  buffer read address, y*H_PIXELS+x
- `reading`  out  1  high while addresses are being issued
- `pixel_in`  in  1  buffer `pixel_out`, 1 = foreground
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle on
- `pixel_count`  out  17  foreground pixels in the frame, 0..76800
- `empty`  out  1  `pixel_count`==0
- `min_x`, `max_x`  out  9  bounding box columns
- `min_y`, `max_y`  out  8  bounding box rows
- `centroid_x`  out  9  floor(sum_x / pixel_count)
- `centroid_y`  out  8  floor(sum_y / pixel_count)

## Operation
- FSM states: IDLE, SCAN, DRAIN, DIV_X, DIV_Y, DONE.
- IDLE→SCAN when `start`=1. On entry, the accumulators clear:
  - count, sum_x, sum_y = 0
  - min_x = 511, min_y = 255
  - max_x = max_y = 0
- SCAN: `reading`=1.
  - `read_addr` steps 0..76799, one per cycle.
  - x/y counters track it: x wraps at H_PIXELS-1 and increments y.
  - Leave for DRAIN after issuing address 76799.
- x, y and a valid bit are carried through a READ_LATENCY-deep delay line. When delayed valid && `pixel_in`:
  - count += 1, sum_x += x, sum_y += y
  - min/max update
- DRAIN: `reading`=0 for exactly READ_LATENCY cycles, absorbing the trailing pixels.
- DIV_X / DIV_Y: the shared divider computes sum_x/count, then sum_y/count.
  - If count==0, both states are skipped. Centroid and bbox results are forced to 0 and `empty`=1.
- DONE: latch all results, pulse `done`, return to IDLE.
- Result outputs hold their values until the next DONE.
- Widths:
  - sum_x and sum_y are 25 bits unsigned (max 76800*319 < 2^25).
  - Quotients are truncated to output width; they are guaranteed in range.
- `read_addr`=0 whenever `reading`=0.

## Timing
- Reset values: every output 0, FSM in IDLE. Accumulators and divider clear asynchronously.
- Reset asserted mid-operation aborts immediately; the frame is lost. Next `start` after release runs normally.
- `start` sampled high at edge N:
  - `reading`=1, `read_addr`=0 during cycle N+1
  - address 76799 in cycle N+76800
- Divider: 1 load cycle + 25 iteration cycles per quotient.
- `done` is high in cycle N+76800+READ_LATENCY+53: 76855 at default parameters, 76803 when empty.
- `start` while `busy` is ignored, including `start` coincident with `done`.

## Structure
- Package `silhouette_pkg` holds:
  - H_PIXELS, V_PIXELS, FRAME_PIXELS=76800, ADDR_W=17, SUM_W=25
  - the FSM state enum typedef
  - this package is shared with the buffer and its writer
- Sub-module `seq_divider`:
  - parameter WIDTH=25
  - ports `start`, dividend, divisor, `ready` pulse, quotient
  - restoring algorithm, one bit per cycle
  - same clock/reset convention

## Test plan
The bench models the buffer as a behavioural array with READ_LATENCY=2.
- All-zero frame, `start` → `done`, `pixel_count`=0, `empty`=1, all other results 0, done at cycle 76803.
- Single 1 at address 641 → count 1, centroid (1,2), bbox x 1..1, y 2..2.
- Ones where x≥160, all rows → count 38400, centroid (239,119), bbox x 160..319, y 0..239.
- Full frame of ones → count 76800, centroid (159,119), bbox 0..319, 0..239, `done` exactly 76855 cycles after `start`, one cycle wide.
- Second `start` pulsed at cycle 1000 of a scan → ignored, results identical to a single run.
- `reset`=0 at cycle 40000 of SCAN → all outputs 0 while in reset, `reading`=0. Restart yields the correct full-frame result.

Source files
------------

// File: rtl/silhouette_pkg.sv
// Shared constants and types for the silhouette frame buffer, its writer and
// the statistics scanner.
package silhouette_pkg;

  localparam int H_PIXELS     = 320;
  localparam int V_PIXELS     = 240;
  localparam int FRAME_PIXELS = H_PIXELS * V_PIXELS;
  localparam int READ_LATENCY = 2;

  localparam int ADDR_W = 17;
  localparam int SUM_W  = 25;
  localparam int CNT_W  = 17;
  localparam int X_W    = 9;
  localparam int Y_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    DIV_X,
    DIV_Y,
    DONE
  } state_e;

  // One stage of the coordinate delay line that follows the read pipeline.
  typedef struct packed {
    logic           v;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } tap_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// `start` loads the operands; `ready` is high in the last iteration cycle and
// `quotient` carries the final result during that same cycle.
module seq_divider #(
  parameter int WIDTH = 25,
  parameter int OUT_W = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic [OUT_W-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // One restoring step: shift in the next dividend bit, try to subtract.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign ready    = busy_q && (cnt_q == CW'(1));
  assign quotient = quo_d[OUT_W-1:0];

  // Operand load and iteration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      cnt_q  <= CW'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/silhouette_stats.sv
// Scans one silhouette frame per start and reports foreground count,
// bounding box and floor-rounded centroid.
module silhouette_stats #(
  parameter int H_PIXELS     = silhouette_pkg::H_PIXELS,
  parameter int V_PIXELS     = silhouette_pkg::V_PIXELS,
  parameter int READ_LATENCY = silhouette_pkg::READ_LATENCY
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic [silhouette_pkg::ADDR_W-1:0] read_addr,
  output logic                             reading,
  input  logic                             pixel_in,
  output logic                             busy,
  output logic                             done,
  output logic [silhouette_pkg::CNT_W-1:0]  pixel_count,
  output logic                             empty,
  output logic [silhouette_pkg::X_W-1:0]    min_x,
  output logic [silhouette_pkg::X_W-1:0]    max_x,
  output logic [silhouette_pkg::Y_W-1:0]    min_y,
  output logic [silhouette_pkg::Y_W-1:0]    max_y,
  output logic [silhouette_pkg::X_W-1:0]    centroid_x,
  output logic [silhouette_pkg::Y_W-1:0]    centroid_y
);

  import silhouette_pkg::*;

  localparam int FRAME = H_PIXELS * V_PIXELS;
  localparam int DRN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e            state_q, state_d;
  logic              first_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  tap_t              dly_q [READ_LATENCY];
  tap_t              tap;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sx_q, sx_d, sy_q, sy_d;
  logic [X_W-1:0]    minx_q, minx_d, maxx_q, maxx_d;
  logic [Y_W-1:0]    miny_q, miny_d, maxy_q, maxy_d;
  logic [X_W-1:0]    cx_q, cx_d;

  logic              hit;
  logic              latch;
  logic              div_start;
  logic              div_ready;
  logic [SUM_W-1:0]  div_dividend;
  logic [X_W-1:0]    div_quo;

  assign tap          = dly_q[READ_LATENCY-1];
  assign hit          = tap.v && pixel_in;
  assign reading      = (state_q == SCAN);
  assign read_addr    = reading ? addr_q : '0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign div_start    = first_q && ((state_q == DIV_X) || (state_q == DIV_Y));
  assign div_dividend = (state_q == DIV_Y) ? sy_q : sx_q;

  seq_divider #(
    .WIDTH (SUM_W),
    .OUT_W (X_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (SUM_W'(cnt_q)),
    .ready    (div_ready),
    .quotient (div_quo)
  );

  // Next state, scan counters and pixel accumulation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    minx_d  = minx_q;
    maxx_d  = maxx_q;
    miny_d  = miny_q;
    maxy_d  = maxy_q;
    cx_d    = cx_q;
    latch   = 1'b0;

    if (hit) begin
      cnt_d = cnt_q + CNT_W'(1);
      sx_d  = sx_q + SUM_W'(tap.x);
      sy_d  = sy_q + SUM_W'(tap.y);
      if (tap.x < minx_q) minx_d = tap.x;
      if (tap.x > maxx_q) maxx_d = tap.x;
      if (tap.y < miny_q) miny_d = tap.y;
      if (tap.y > maxy_q) maxy_d = tap.y;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          sx_d    = '0;
          sy_d    = '0;
          minx_d  = '1;
          miny_d  = '1;
          maxx_d  = '0;
          maxy_d  = '0;
        end
      end
      SCAN: begin
        if (addr_q == ADDR_W'(FRAME - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_q == X_W'(H_PIXELS - 1)) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      DRAIN: begin
        // The last pixel lands on this same edge, so the empty decision
        // must look at the post-update count.
        if (drain_q == DRN_W'(READ_LATENCY - 1)) begin
          if (cnt_d == '0) begin
            state_d = DONE;
            latch   = 1'b1;
          end else begin
            state_d = DIV_X;
          end
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      DIV_X: begin
        if (div_ready) begin
          cx_d    = div_quo;
          state_d = DIV_Y;
        end
      end
      DIV_Y: begin
        if (div_ready) begin
          state_d = DONE;
          latch   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, scan and accumulator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= '0;
      cnt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      minx_q  <= '0;
      maxx_q  <= '0;
      miny_q  <= '0;
      maxy_q  <= '0;
      cx_q    <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      minx_q  <= minx_d;
      maxx_q  <= maxx_d;
      miny_q  <= miny_d;
      maxy_q  <= maxy_d;
      cx_q    <= cx_d;
    end
  end

  // Coordinate delay line aligned with the buffer read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= '{v: reading, x: x_q, y: y_q};
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Result registers, loaded on the edge that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_count <= '0;
      empty       <= 1'b0;
      min_x       <= '0;
      max_x       <= '0;
      min_y       <= '0;
      max_y       <= '0;
      centroid_x  <= '0;
      centroid_y  <= '0;
    end else if (latch) begin
      pixel_count <= cnt_d;
      if (cnt_d == '0) begin
        empty      <= 1'b1;
        min_x      <= '0;
        max_x      <= '0;
        min_y      <= '0;
        max_y      <= '0;
        centroid_x <= '0;
        centroid_y <= '0;
      end else begin
        empty      <= 1'b0;
        min_x      <= minx_d;
        max_x      <= maxx_d;
        min_y      <= miny_d;
        max_y      <= maxy_d;
        centroid_x <= cx_d;
        centroid_y <= div_quo[Y_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_silhouette_stats.sv
// Scoreboard bench for silhouette_stats on a reduced 32x24 frame.
module tb_silhouette_stats;

  localparam int H         = 32;
  localparam int V         = 24;
  localparam int FRAME     = H * V;
  localparam int LAT       = 2;
  localparam int DONE_LAT  = FRAME + LAT + 53;
  localparam int EMPTY_LAT = FRAME + LAT + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [16:0] read_addr;
  logic        reading;
  logic        pixel_in;
  logic        busy;
  logic        done;
  logic [16:0] pixel_count;
  logic        empty;
  logic [8:0]  min_x, max_x, centroid_x;
  logic [7:0]  min_y, max_y, centroid_y;

  bit   mem [FRAME];
  logic p1 = 1'b0;
  logic p2 = 1'b0;

  typedef struct {
    logic [16:0] count;
    logic        empty;
    logic [8:0]  min_x, max_x, cx;
    logic [7:0]  min_y, max_y, cy;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  silhouette_stats #(
    .H_PIXELS     (H),
    .V_PIXELS     (V),
    .READ_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .read_addr   (read_addr),
    .reading     (reading),
    .pixel_in    (pixel_in),
    .busy        (busy),
    .done        (done),
    .pixel_count (pixel_count),
    .empty       (empty),
    .min_x       (min_x),
    .max_x       (max_x),
    .min_y       (min_y),
    .max_y       (max_y),
    .centroid_x  (centroid_x),
    .centroid_y  (centroid_y)
  );

  always #5 clk = ~clk;

  // Behavioural frame buffer with a two-cycle read pipeline.
  always @(posedge clk) begin
    p1 <= (read_addr < 17'(FRAME)) ? mem[read_addr] : 1'b0;
    p2 <= p1;
  end
  assign pixel_in = p2;

  task automatic fill(input int kind);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        case (kind)
          1:       mem[y*H+x] = ((y*H+x) == 2*H+1);
          2:       mem[y*H+x] = (x >= H/2);
          3:       mem[y*H+x] = 1'b1;
          default: mem[y*H+x] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic push_expected();
    int     c;
    longint sx, sy;
    int     mnx, mxx, mny, mxy;
    exp_t   e;
    c = 0; sx = 0; sy = 0;
    mnx = H; mxx = -1; mny = V; mxy = -1;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (mem[y*H+x]) begin
          c++;
          sx += x;
          sy += y;
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
      end
    end
    e.count = 17'(c);
    if (c == 0) begin
      e.empty = 1'b1;
      e.min_x = '0; e.max_x = '0; e.min_y = '0; e.max_y = '0;
      e.cx = '0; e.cy = '0;
      e.lat = EMPTY_LAT;
    end else begin
      e.empty = 1'b0;
      e.min_x = 9'(mnx); e.max_x = 9'(mxx);
      e.min_y = 8'(mny); e.max_y = 8'(mxy);
      e.cx = 9'(sx / c);
      e.cy = 8'(sy / c);
      e.lat = DONE_LAT;
    end
    exp_q.push_back(e);
  endtask

  task automatic score_frame(input string tag, input int lat);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s scoreboard: done seen with no expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if (lat !== e.lat) begin miscompares++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, e.lat); end
    vectors++;
    if (pixel_count !== e.count) begin miscompares++;
      $display("FAIL %s count: got %0d want %0d", tag, pixel_count, e.count); end
    vectors++;
    if (empty !== e.empty) begin miscompares++;
      $display("FAIL %s empty: got %b want %b", tag, empty, e.empty); end
    vectors++;
    if ({min_x, max_x} !== {e.min_x, e.max_x}) begin miscompares++;
      $display("FAIL %s bbox_x: got %0d..%0d want %0d..%0d", tag, min_x, max_x, e.min_x, e.max_x); end
    vectors++;
    if ({min_y, max_y} !== {e.min_y, e.max_y}) begin miscompares++;
      $display("FAIL %s bbox_y: got %0d..%0d want %0d..%0d", tag, min_y, max_y, e.min_y, e.max_y); end
    vectors++;
    if (centroid_x !== e.cx) begin miscompares++;
      $display("FAIL %s centroid_x: got %0d want %0d", tag, centroid_x, e.cx); end
    vectors++;
    if (centroid_y !== e.cy) begin miscompares++;
      $display("FAIL %s centroid_y: got %0d want %0d", tag, centroid_y, e.cy); end
  endtask

  // Pulses start, follows the scan, and scores the result on done.
  task automatic run_frame(input string tag, input int restart_at,
                           input bit start_on_done, output int lat);
    int n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    vectors++;
    if (reading !== 1'b1 || read_addr !== 17'd0) begin miscompares++;
      $display("FAIL %s first_addr: got reading=%b addr=%0d want 1/0", tag, reading, read_addr); end
    while (done !== 1'b1 && n < FRAME + 200) begin
      if (n == FRAME) begin
        vectors++;
        if (reading !== 1'b1 || read_addr !== 17'(FRAME - 1)) begin miscompares++;
          $display("FAIL %s last_addr: got reading=%b addr=%0d want 1/%0d", tag, reading, read_addr, FRAME - 1); end
      end
      if (n == FRAME + 1) begin
        vectors++;
        if (reading !== 1'b0 || read_addr !== 17'd0) begin miscompares++;
          $display("FAIL %s drain_idle: got reading=%b addr=%0d want 0/0", tag, reading, read_addr); end
      end
      if (n == restart_at) begin
        vectors++;
        if (busy !== 1'b1) begin miscompares++;
          $display("FAIL %s busy_mid: got %b want 1", tag, busy); end
      end
      start = (n == restart_at);
      @(negedge clk); n++;
    end
    start = 1'b0;
    lat = n;
    vectors++;
    if (done !== 1'b1) begin miscompares++;
      $display("FAIL %s done_timeout: got done=%b after %0d cycles want 1", tag, done, n); end
    score_frame(tag, lat);
    start = start_on_done;
    @(negedge clk); start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0/0", tag, done, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({read_addr, reading, busy, done, pixel_count, empty, min_x, max_x,
         min_y, max_y, centroid_x, centroid_y} !== '0) begin miscompares++;
      $display("FAIL reset_outputs: got addr=%0d rd=%b busy=%b done=%b cnt=%0d empty=%b want all 0",
               read_addr, reading, busy, done, pixel_count, empty); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    int lat;
    fill(0); push_expected();
    run_frame("empty", 0, 1'b0, lat);
  endtask

  task automatic test_single();
    int lat;
    fill(1); push_expected();
    run_frame("single", 0, 1'b0, lat);
    vectors++;
    if ({centroid_x, centroid_y, pixel_count} !== {9'd1, 8'd2, 17'd1}) begin miscompares++;
      $display("FAIL single_fixed: got (%0d,%0d) n=%0d want (1,2) n=1", centroid_x, centroid_y, pixel_count); end
  endtask

  task automatic test_half();
    int lat;
    fill(2); push_expected();
    run_frame("half", 0, 1'b0, lat);
  endtask

  task automatic test_full();
    int lat;
    fill(3); push_expected();
    run_frame("full", 0, 1'b1, lat);
    vectors++;
    if (lat !== DONE_LAT) begin miscompares++;
      $display("FAIL full_latency_fixed: got %0d want %0d", lat, DONE_LAT); end
  endtask

  task automatic test_start_ignored();
    int lat;
    fill(2); push_expected();
    run_frame("restart_ignored", 200, 1'b0, lat);
  endtask

  task automatic test_reset_abort();
    int lat;
    fill(3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (FRAME/2 - 1) @(negedge clk);
    vectors++;
    if (reading !== 1'b1) begin miscompares++;
      $display("FAIL abort_midscan: got reading=%b want 1", reading); end
    reset = 1'b0; #1;
    vectors++;
    if ({read_addr, reading, busy, done, pixel_count, empty, min_x, max_x,
         min_y, max_y, centroid_x, centroid_y} !== '0) begin miscompares++;
      $display("FAIL abort_outputs: got addr=%0d rd=%b busy=%b cnt=%0d want all 0",
               read_addr, reading, busy, pixel_count); end
    @(negedge clk);
    vectors++;
    if (reading !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL abort_held: got reading=%b busy=%b want 0/0", reading, busy); end
    reset = 1'b1;
    @(negedge clk);
    push_expected();
    run_frame("after_abort", 0, 1'b0, lat);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_half();
    test_full();
    test_start_ignored();
    test_reset_abort();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
